pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register, the general form of our fixed ID→EXE latch. It carries an opaque WIDTH-bit payload between any two core stages with a valid/ready handshake, synchronous flush for branch/trap redirect, and an optional 2-entry skid buffer that keeps full throughput with a fully registered `in_ready_o`. A saturating back-pressure counter is exported for performance monitoring.

---
 rtl/pipe_stage_reg.sv | 71 +++++++
 tb/tb_pipe_stage_reg.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush, optional 2-entry skid buffer and saturating stall counter
module pipe_stage_reg #(
  parameter int WIDTH = 32,
  parameter int SKID = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  logic             mv;
  logic [WIDTH-1:0] m;
  logic             in_fire;
  logic             out_fire;
  assign out_valid_o = mv;
  assign out_data_o  = m;
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = mv & out_ready_i;
  if (SKID != 0) begin : g_skid
    logic             sv;
    logic [WIDTH-1:0] s;
    assign in_ready_o = ~sv;
    // EMPTY/ONE/FULL occupancy; S only fills when M is held, and drains into M first
    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
        mv <= 1'b0;
        sv <= 1'b0;
        m  <= '0;
        s  <= '0;
      end else if (flush_i) begin
        mv <= 1'b0;
        sv <= 1'b0;
      end else if (sv) begin
        if (out_fire) begin
          m  <= s;
          sv <= 1'b0;
        end
      end else if (in_fire) begin
        if (~mv | out_fire) begin
          m  <= in_data_i;
          mv <= 1'b1;
        end else begin
          s  <= in_data_i;
          sv <= 1'b1;
        end
      end else if (out_fire) mv <= 1'b0;
  end else begin : g_single
    assign in_ready_o = ~mv | out_ready_i;
    // single entry: refill M whenever it is empty or being emptied this cycle
    always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
        mv <= 1'b0;
        m  <= '0;
      end else if (flush_i) mv <= 1'b0;
      else if (in_fire) begin
        m  <= in_data_i;
        mv <= 1'b1;
      end else if (out_fire) mv <= 1'b0;
  end
  // back-pressure cycles, saturating; flush does not clear it
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) stall_cnt_o <= '0;
    else if (mv & ~out_ready_i & ~&stall_cnt_o) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and random checks of pipe_stage_reg against a queue scoreboard
module tb_pipe_stage_reg;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready1, ov1, in_ready0, ov0, in_ready4, ov4;
  logic [31:0] od1, od0, od4;
  logic [15:0] stall1, stall0;
  logic [3:0]  stall4;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];
  always #5 clk = ~clk;
  pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNT_W(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .in_data_i(in_data), .out_valid_o(ov1), .out_ready_i(out_ready), .out_data_o(od1), .stall_cnt_o(stall1));
  pipe_stage_reg #(.WIDTH(32), .SKID(0), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .in_data_i(in_data), .out_valid_o(ov0), .out_ready_i(out_ready), .out_data_o(od0), .stall_cnt_o(stall0));
  pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready4),
    .in_data_i(in_data), .out_valid_o(ov4), .out_ready_i(out_ready), .out_data_o(od4), .stall_cnt_o(stall4));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    q1.delete();
    q0.delete();
    step;
    step;
    rst = 1'b0;
  endtask
  // occupancy/order scoreboard for the skid instance: in_ready is ~FULL, output is queue head
  always @(negedge clk)
    if (!rst) begin
      chk("sb1 in_ready", in_ready1, q1.size() < 2);
      chk("sb1 valid", ov1, q1.size() != 0);
      if (q1.size() != 0) chk("sb1 data", od1, q1[0]);
      if (ov1 && out_ready && q1.size() != 0) void'(q1.pop_front());
      if (flush) q1.delete();
      else if (in_valid && in_ready1) q1.push_back(in_data);
    end
  // same for the single-entry instance, whose ready follows out_ready when full
  always @(negedge clk)
    if (!rst) begin
      chk("sb0 in_ready", in_ready0, q0.size() == 0 || out_ready);
      chk("sb0 valid", ov0, q0.size() != 0);
      if (q0.size() != 0) chk("sb0 data", od0, q0[0]);
      if (ov0 && out_ready && q0.size() != 0) void'(q0.pop_front());
      if (flush) q0.delete();
      else if (in_valid && in_ready0) q0.push_back(in_data);
    end
  initial begin
    logic r;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hA5;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst valid", ov1, 1'b0);
    chk("rst data", od1, 32'h0);
    chk("rst in_ready", in_ready1, 1'b1);
    chk("rst stall", stall1, 16'h0);
    chk("rst in_ready skid0", in_ready0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    chk("first valid", ov1, 1'b1);
    chk("first data", od1, 32'hA5);
    chk("first data skid0", od0, 32'hA5);
    do_reset;
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data = i;
      step;
      chk("stream skid1", od1, i);
      chk("stream skid0", od0, i);
      chk("stream valid", ov1 & ov0, 1'b1);
    end
    in_valid = 1'b0;
    chk("stream stall1", stall1, 16'h0);
    chk("stream stall0", stall0, 16'h0);
    do_reset;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 32'h1;
    step;
    out_ready = 1'b0;
    in_data = 32'h2;
    step;
    chk("bp held M", od1, 32'h1);
    chk("bp ready low", in_ready1, 1'b0);
    in_data = 32'h3;
    step;
    step;
    chk("bp stall", stall1, 16'd3);
    chk("bp still M", od1, 32'h1);
    out_ready = 1'b1;
    step;
    chk("bp drain S", od1, 32'h2);
    chk("bp ready back", in_ready1, 1'b1);
    step;
    chk("bp third", od1, 32'h3);
    in_valid = 1'b0;
    step;
    chk("bp empty", ov1, 1'b0);
    do_reset;
    in_valid = 1'b1;
    in_data = 32'h11;
    step;
    in_data = 32'h22;
    step;
    chk("full M", od1, 32'h11);
    chk("full ready", in_ready1, 1'b0);
    flush = 1'b1;
    in_data = 32'h33;
    step;
    flush = 1'b0;
    in_data = 32'h44;
    out_ready = 1'b1;
    chk("flush valid", ov1, 1'b0);
    chk("flush ready", in_ready1, 1'b1);
    step;
    chk("post flush data", od1, 32'h44);
    chk("post flush valid", ov1, 1'b1);
    flush = 1'b1;
    in_data = 32'h66;
    step;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush drops in_fire", ov1, 1'b0);
    chk("flush drops skid0", ov0, 1'b0);
    do_reset;
    in_valid = 1'b1;
    in_data = 32'h55;
    step;
    in_valid = 1'b0;
    repeat (20) step;
    chk("sat cnt4", stall4, 4'hF);
    chk("wide cnt", stall1, 16'd20);
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("sat after flush", stall4, 4'hF);
    chk("flush empties", ov4, 1'b0);
    in_valid = 1'b1;
    in_data = 32'h77;
    step;
    in_valid = 1'b0;
    chk("inflight valid", ov1, 1'b1);
    rst = 1'b1;
    q1.delete();
    q0.delete();
    #1;
    chk("async rst valid", ov1, 1'b0);
    chk("async rst data", od1, 32'h0);
    chk("async rst cnt4", stall4, 4'h0);
    chk("async rst ready", in_ready1, 1'b1);
    step;
    rst = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 49) == 0;
      in_data = $urandom;
      r = in_ready1;
      out_ready = ~out_ready;
      #1;
      chk("skid ready comb", in_ready1, r);
      out_ready = ~out_ready;
      #1;
      step;
    end
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (4) step;
    chk("drain q1", q1.size(), 0);
    chk("drain q0", q0.size(), 0);
    chk("drain valid", ov1 | ov0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
